// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: two-way intersection light sequencer with pedestrian walk phase and flashing mode
module traffic_intersection_ctrl #(
  parameter int GREEN_T = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T = 6,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  input logic enable,
  input logic ped_req,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic [2:0] phase,
  output logic ped_pending
);
  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
    NS_GREEN = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_B = 3'd3,
    EW_GREEN = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK = 3'd6,
    FLASH = 3'd7
  } state_t;
  state_t state, state_n, seq;
  logic [CNT_W-1:0] cnt, cnt_n, dwell;
  logic flash, flash_n, pend_n, done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ALL_RED_A;
      cnt <= '0;
      flash <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      flash <= flash_n;
      ped_pending <= pend_n;
    end
  end
  always_comb begin
    seq = ALL_RED_A;
    case (state)
      ALL_RED_A: seq = NS_GREEN;
      NS_GREEN: seq = NS_YELLOW;
      NS_YELLOW: seq = ALL_RED_B;
      ALL_RED_B: seq = EW_GREEN;
      EW_GREEN: seq = EW_YELLOW;
      EW_YELLOW: seq = ped_pending ? PED_WALK : ALL_RED_A;
      default: seq = ALL_RED_A;
    endcase
    dwell = (state == NS_GREEN || state == EW_GREEN) ? CNT_W'(GREEN_T - 1) :
            (state == NS_YELLOW || state == EW_YELLOW) ? CNT_W'(YELLOW_T - 1) :
            (state == PED_WALK) ? CNT_W'(WALK_T - 1) :
            (state == FLASH) ? CNT_W'(FLASH_HALF - 1) : CNT_W'(ALLRED_T - 1);
    done = cnt == dwell;
    state_n = !enable ? FLASH : (state == FLASH) ? ALL_RED_A : done ? seq : state;
    cnt_n = (state_n != state || done) ? '0 : cnt + 1'b1;
    flash_n = (state_n != FLASH) ? 1'b0 : (state != FLASH) ? 1'b1 : done ? ~flash : flash;
    pend_n = ((state_n == PED_WALK && state != PED_WALK) || (state_n == FLASH && state != FLASH)) ? 1'b0 :
             (ped_req && state != PED_WALK && state != FLASH) ? 1'b1 : ped_pending;
  end
  assign ns_green = state == NS_GREEN;
  assign ns_yellow = state == NS_YELLOW || (state == FLASH && flash);
  assign ns_red = !(state == NS_GREEN || state == NS_YELLOW || state == FLASH);
  assign ew_green = state == EW_GREEN;
  assign ew_yellow = state == EW_YELLOW || (state == FLASH && flash);
  assign ew_red = !(state == EW_GREEN || state == EW_YELLOW || state == FLASH);
  assign walk = state == PED_WALK;
  assign phase = state;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: directed scenarios checked every cycle against a time-based reference model
module tb_traffic_intersection_ctrl;
  localparam int FH = 4;
  localparam logic [6:0] RED = 7'b1001000;
  localparam logic [6:0] NSG = 7'b0011000;
  localparam logic [6:0] NSY = 7'b0101000;
  localparam logic [6:0] EWG = 7'b1000010;
  localparam logic [6:0] EWY = 7'b1000100;
  localparam logic [6:0] WLK = 7'b1001001;
  localparam logic [6:0] FY = 7'b0100100;
  localparam logic [6:0] OFF = 7'b0000000;
  logic clk = 0, reset = 1, enable = 0, ped_req = 0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;
  logic [2:0] phase;
  logic [6:0] lv;
  int n_chk = 0, n_fail = 0, t = 0;
  int m_ph = 0, m_el = 0;
  bit m_pend = 0, armed = 0;
  traffic_intersection_ctrl #(
    .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2), .WALK_T(6), .FLASH_HALF(FH), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .phase(phase), .ped_pending(ped_pending)
  );
  assign lv = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
  always #5 clk = ~clk;
  function automatic int dur(int p);
    return (p == 1 || p == 4) ? 8 : (p == 2 || p == 5) ? 3 : (p == 6) ? 6 : 2;
  endfunction
  function automatic int nxt(int p, bit pend);
    return (p == 5) ? (pend ? 6 : 0) : (p == 6) ? 0 : p + 1;
  endfunction
  function automatic logic [6:0] lamps(int p, int fe);
    logic f;
    f = ((fe / FH) % 2) == 0;
    return {!(p == 1 || p == 2 || p == 7), p == 2 || (p == 7 && f), p == 1,
            !(p == 4 || p == 5 || p == 7), p == 5 || (p == 7 && f), p == 4, p == 6};
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at obs %0d: got %0h expected %0h", name, t, got, exp);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_ph <= 0;
      m_el <= 0;
      m_pend <= 0;
      armed <= 1;
    end else if (!enable) begin
      m_ph <= 7;
      m_el <= (m_ph == 7) ? m_el + 1 : 0;
      if (m_ph != 7) m_pend <= 0;
    end else if (m_ph == 7) begin
      m_ph <= 0;
      m_el <= 0;
    end else if (m_el + 1 == dur(m_ph)) begin
      m_ph <= nxt(m_ph, m_pend);
      m_el <= 0;
      m_pend <= (nxt(m_ph, m_pend) == 6) ? 1'b0 : (ped_req && m_ph != 6) ? 1'b1 : m_pend;
    end else begin
      m_el <= m_el + 1;
      if (ped_req && m_ph != 6) m_pend <= 1;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("model_phase", phase, m_ph);
      chk("model_lamps", lv, lamps(m_ph, m_el));
      chk("model_ped_pending", ped_pending, m_pend);
      if (phase != 3'd7) begin
        chk("one_lamp_ns", $countones({ns_red, ns_yellow, ns_green}), 1);
        chk("one_lamp_ew", $countones({ew_red, ew_yellow, ew_green}), 1);
        chk("no_conflict", ns_red | ew_red, 1);
      end
    end
  end
  task automatic go(int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic lit(int k, int ph, logic [6:0] lp, bit pend);
    go(k);
    chk("lit_phase", phase, ph);
    chk("lit_lamps", lv, lp);
    chk("lit_ped_pending", ped_pending, pend);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    t = 0;
    lit(0, 0, RED, 0);
    reset = 0;
    enable = 1;
    lit(1, 0, RED, 0);
    lit(2, 1, NSG, 0);
    lit(9, 1, NSG, 0);
    lit(10, 2, NSY, 0);
    lit(13, 3, RED, 0);
    lit(15, 4, EWG, 0);
    lit(23, 5, EWY, 0);
    lit(25, 5, EWY, 0);
    lit(26, 0, RED, 0);
    lit(52, 0, RED, 0);
    go(55); ped_req = 1;
    go(56); ped_req = 0;
    lit(56, 1, NSG, 1);
    lit(77, 5, EWY, 1);
    lit(78, 6, WLK, 0);
    lit(83, 6, WLK, 0);
    lit(84, 0, RED, 0);
    go(86); ped_req = 1;
    lit(109, 5, EWY, 1);
    lit(110, 6, WLK, 0);
    go(115); ped_req = 0;
    lit(115, 6, WLK, 0);
    lit(116, 0, RED, 0);
    lit(141, 5, EWY, 0);
    lit(142, 0, RED, 0);
    go(144); ped_req = 1;
    go(145); ped_req = 0;
    lit(145, 1, NSG, 1);
    go(159); enable = 0;
    lit(159, 4, EWG, 1);
    lit(160, 7, FY, 0);
    lit(163, 7, FY, 0);
    lit(164, 7, OFF, 0);
    go(165); ped_req = 1;
    go(166); ped_req = 0;
    lit(167, 7, OFF, 0);
    lit(168, 7, FY, 0);
    go(169); enable = 1;
    lit(170, 0, RED, 0);
    go(172); ped_req = 1;
    go(173); ped_req = 0;
    lit(173, 1, NSG, 1);
    lit(196, 6, WLK, 0);
    go(198); reset = 1; ped_req = 1;
    lit(198, 6, WLK, 0);
    go(199); reset = 0; ped_req = 0;
    lit(199, 0, RED, 0);
    lit(201, 1, NSG, 0);
    lit(225, 0, RED, 0);
    go(227); enable = 0;
    lit(228, 7, FY, 0);
    go(230); reset = 1;
    lit(231, 0, RED, 0);
    reset = 0;
    lit(232, 7, FY, 0);
    go(233); enable = 1;
    lit(234, 0, RED, 0);
    go(260);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
